// File: rtl/fetch_queue_pkg.sv
// ---------------------------------------------------------------------------
// fetch_queue_pkg
//   Shared definitions for the instruction-fetch front end: default reset PC,
//   the nop encoding driven when the queue is empty, the {pc, instr} entry
//   layout stored in the FIFO, and the word-address increment helper.
// ---------------------------------------------------------------------------
package fetch_queue_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'd0;
    localparam logic [31:0] NOP_INSTR        = 32'b0;
    localparam int unsigned FQ_ENTRY_W       = 64;

    // One buffered fetch result; pc occupies the upper word.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fq_entry_t;

    // Word-addressed PC increment; wraps naturally at 32 bits.
    function automatic logic [31:0] pc_next(input logic [31:0] pc);
        return pc + 32'd1;
    endfunction

endpackage

// File: rtl/fq_storage.sv
// ---------------------------------------------------------------------------
// fq_storage
//   DEPTH x 64-bit register array backing the fetch queue. One rising-edge
//   write port and one asynchronous read port so the head entry is visible
//   to decode in the same cycle it becomes valid.
// Ports
//   clock    in   rising-edge clock
//   wr_en    in   write enable (push)
//   wr_ptr   in   write index
//   wr_data  in   {pc, instr} entry to store
//   rd_ptr   in   read index (queue head)
//   rd_data  out  entry at rd_ptr, combinational
// ---------------------------------------------------------------------------
module fq_storage
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic             clock,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_ptr,
    input  fq_entry_t        wr_data,
    input  logic [PTR_W-1:0] rd_ptr,
    output fq_entry_t        rd_data
);

    fq_entry_t mem_q [DEPTH];
    fq_entry_t mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_ptr] = wr_data;
        end
    end

    // Payload storage carries no reset; validity is tracked by the top's count.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    assign rd_data = mem_q[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_queue
//   Instruction-fetch front end. Owns the PC, issues one word fetch per cycle
//   to imem while credit allows, captures the response one cycle later into a
//   DEPTH-entry FIFO of {pc, instr}, and presents the head to decode with a
//   valid/ready handshake. A redirect from execute flushes everything (queue
//   and the pending imem response) and restarts fetch at redirect_pc.
// Ports
//   clock          in   rising-edge clock
//   reset          in   synchronous, active-low
//   imem_addr      out  word address to imem (the pc register)
//   imem_en        out  fetch issued this cycle
//   imem_rdata     in   imem data, valid the cycle after imem_en
//   out_valid      out  head entry available
//   out_ready      in   decode accepts head this cycle
//   out_instr      out  head instruction, nop when !out_valid
//   out_pc         out  head PC, zero when !out_valid
//   redirect_valid in   flush and redirect
//   redirect_pc    in   new fetch address
// ---------------------------------------------------------------------------
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] imem_addr,
    output logic        imem_en,
    input  logic [31:0] imem_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W:0]   DEPTH_CRED = (CNT_W + 1)'(DEPTH);

    logic [31:0]      pc_q,          pc_d;
    logic             inflight_q,    inflight_d;
    logic [31:0]      inflight_pc_q, inflight_pc_d;
    logic [PTR_W-1:0] wr_ptr_q,      wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q,      rd_ptr_d;
    logic [CNT_W-1:0] count_q,       count_d;

    logic             issue;
    logic             push;
    logic             pop;
    logic [CNT_W:0]   credit_used;
    fq_entry_t        wr_entry;
    fq_entry_t        head_entry;

    // Credit covers buffered entries plus the fetch still in flight, so a
    // response always has a slot waiting. A pop this cycle is deliberately
    // not credited back until next cycle.
    assign credit_used = {1'b0, count_q} + (CNT_W + 1)'(inflight_q);

    assign issue = reset & ~redirect_valid & (credit_used < DEPTH_CRED);
    assign push  = reset & ~redirect_valid & inflight_q;

    assign out_valid = reset & (count_q != '0);
    assign pop       = out_valid & out_ready & ~redirect_valid;

    assign imem_en   = issue;
    assign imem_addr = reset ? pc_q : RESET_PC;
    assign out_instr = out_valid ? head_entry.instr : NOP_INSTR;
    assign out_pc    = out_valid ? head_entry.pc    : 32'b0;

    assign wr_entry.pc    = inflight_pc_q;
    assign wr_entry.instr = imem_rdata;

    always_comb begin
        pc_d          = pc_q;
        inflight_d    = inflight_q;
        inflight_pc_d = inflight_pc_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;

        if (redirect_valid) begin
            // Flush: the response for the in-flight fetch is discarded by
            // clearing inflight, so it never reaches the queue.
            pc_d       = redirect_pc;
            inflight_d = 1'b0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (issue) begin
                pc_d          = pc_next(pc_q);
                inflight_pc_d = pc_q;
            end
            inflight_d = issue;

            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end

            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            pc_q       <= RESET_PC;
            inflight_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            pc_q       <= pc_d;
            inflight_q <= inflight_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Only meaningful while inflight_q is set, so it needs no reset.
    always_ff @(posedge clock) begin
        inflight_pc_q <= inflight_pc_d;
    end

    // The credit rule guarantees a response never arrives to a full queue.
    always_ff @(posedge clock) begin
        if (push) begin
            assert (count_q != DEPTH_CNT);
        end
    end

    fq_storage #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_storage (
        .clock   (clock),
        .wr_en   (push),
        .wr_ptr  (wr_ptr_q),
        .wr_data (wr_entry),
        .rd_ptr  (rd_ptr_q),
        .rd_data (head_entry)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_fetch_queue
//   Directed bench for fetch_queue. A queue-based reference model tracks the
//   fetch stream and is compared against every DUT output each cycle; literal
//   expectations at key points pin the model itself.
// ---------------------------------------------------------------------------
module tb_fetch_queue;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'd0;
    localparam logic [31:0] INSTR_OFS = 32'h100;

    logic        clock;
    logic        reset;
    logic [31:0] imem_addr;
    logic        imem_en;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .imem_addr      (imem_addr),
        .imem_en        (imem_en),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // imem: synchronous read, instr = addr + 0x100; garbage when not enabled.
    always @(posedge clock) begin
        if (imem_en) imem_rdata <= imem_addr + INSTR_OFS;
        else         imem_rdata <= 32'hDEAD_BEEF;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [63:0] mq[$];
    logic [31:0] m_pc  = RESET_PC;
    bit          m_infl = 1'b0;
    logic [31:0] m_ipc  = 32'd0;

    always @(negedge clock) begin
        logic        e_en, e_valid;
        logic [31:0] e_addr, e_pc, e_instr;
        e_en    = reset && !redirect_valid && (int'(mq.size()) + int'(m_infl) < int'(DEPTH));
        e_addr  = reset ? m_pc : RESET_PC;
        e_valid = reset && (mq.size() > 0);
        e_pc    = e_valid ? mq[0][63:32] : 32'd0;
        e_instr = e_valid ? mq[0][31:0]  : 32'd0;
        chk("m_imem_en",   32'(imem_en),   32'(e_en));
        chk("m_imem_addr", imem_addr,      e_addr);
        chk("m_out_valid", 32'(out_valid), 32'(e_valid));
        chk("m_out_pc",    out_pc,         e_pc);
        chk("m_out_instr", out_instr,      e_instr);

        if (!reset) begin
            m_pc = RESET_PC; mq.delete(); m_infl = 1'b0;
        end else if (redirect_valid) begin
            m_pc = redirect_pc; mq.delete(); m_infl = 1'b0;
        end else begin
            if (e_valid && out_ready) void'(mq.pop_front());
            if (m_infl) mq.push_back({m_ipc, m_ipc + INSTR_OFS});
            m_infl = e_en;
            if (e_en) begin
                m_ipc = m_pc;
                m_pc  = m_pc + 32'd1;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input bit ready);
        reset = 1'b0; redirect_valid = 1'b0; out_ready = ready;
        step(); step();
        reset = 1'b1;
    endtask

    initial begin
        logic [31:0] pat;
        reset = 1'b0; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'd0;
        step(); step();
        #2;
        chk("rst_en",    32'(imem_en),   32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_addr",  imem_addr,      RESET_PC);
        chk("rst_instr", out_instr,      32'd0);
        step();

        // 1: release with ready high -> sustained stream
        reset = 1'b1;                      // cycle 0
        #2; chk("t1_c0_en", 32'(imem_en), 32'd1); chk("t1_c0_addr", imem_addr, 32'd0);
        step(); #2;                        // cycle 1
        chk("t1_c1_addr", imem_addr, 32'd1); chk("t1_c1_valid", 32'(out_valid), 32'd0);
        step(); #2;                        // cycle 2
        chk("t1_c2_valid", 32'(out_valid), 32'd1);
        chk("t1_c2_pc", out_pc, 32'd0); chk("t1_c2_instr", out_instr, 32'h100);
        step(); #2; chk("t1_c3_pc", out_pc, 32'd1); chk("t1_c3_instr", out_instr, 32'h101);
        step(); #2; chk("t1_c4_pc", out_pc, 32'd2); chk("t1_c4_en", 32'(imem_en), 32'd1);

        // 2: stall 10 cycles, then drain in order without gaps
        step(); do_reset(1'b0);            // cycle 0, ready low
        repeat (10) step();                // cycle 10
        #2;
        chk("t2_full_en", 32'(imem_en), 32'd0);
        chk("t2_full_valid", 32'(out_valid), 32'd1);
        chk("t2_full_pc", out_pc, 32'd0);
        chk("t2_full_addr", imem_addr, 32'd4);
        out_ready = 1'b1;
        #1; chk("t2_c10_en", 32'(imem_en), 32'd0);
        step(); #2; chk("t2_c11_pc", out_pc, 32'd1);
        chk("t2_c11_en", 32'(imem_en), 32'd1); chk("t2_c11_addr", imem_addr, 32'd4);
        step(); #2; chk("t2_c12_pc", out_pc, 32'd2);
        step(); #2; chk("t2_c13_pc", out_pc, 32'd3);
        step(); #2; chk("t2_c14_pc", out_pc, 32'd4); chk("t2_c14_instr", out_instr, 32'h104);

        // 3: redirect with 3 queued and a fetch in flight
        step(); do_reset(1'b0);
        repeat (4) step();                 // cycle 4: 3 queued, pc 3 in flight
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        #2; chk("t3_rd_en", 32'(imem_en), 32'd0);
        step(); redirect_valid = 1'b0; out_ready = 1'b1;
        #2; chk("t3_n1_valid", 32'(out_valid), 32'd0);
        chk("t3_n1_addr", imem_addr, 32'h40); chk("t3_n1_en", 32'(imem_en), 32'd1);
        step(); #2; chk("t3_n2_valid", 32'(out_valid), 32'd0);
        step(); #2; chk("t3_n3_pc", out_pc, 32'h40); chk("t3_n3_instr", out_instr, 32'h140);
        step(); #2; chk("t3_n4_pc", out_pc, 32'h41);

        // 4: redirect coincident with pop on a full queue, then a second redirect
        step(); do_reset(1'b0);
        repeat (6) step();                 // full, nothing in flight
        out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200;
        #2; chk("t4_full_pc", out_pc, 32'd0);
        step(); redirect_pc = 32'h80;
        #2; chk("t4_r1_valid", 32'(out_valid), 32'd0); chk("t4_r1_addr", imem_addr, 32'h200);
        step(); redirect_valid = 1'b0;
        #2; chk("t4_r2_addr", imem_addr, 32'h80); chk("t4_r2_en", 32'(imem_en), 32'd1);
        step(); #2; chk("t4_r3_valid", 32'(out_valid), 32'd0);
        step(); #2; chk("t4_r4_pc", out_pc, 32'h80); chk("t4_r4_instr", out_instr, 32'h180);

        // 5: reset mid-stream (with a simultaneous redirect) wins
        step(); do_reset(1'b0);
        repeat (4) step();
        reset = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h999;
        #2; chk("t5_in_valid", 32'(out_valid), 32'd0); chk("t5_in_pc", out_pc, 32'd0);
        chk("t5_in_en", 32'(imem_en), 32'd0);
        step(); reset = 1'b1; redirect_valid = 1'b0; out_ready = 1'b1;
        #2; chk("t5_n1_valid", 32'(out_valid), 32'd0); chk("t5_n1_instr", out_instr, 32'd0);
        chk("t5_n1_addr", imem_addr, RESET_PC); chk("t5_n1_en", 32'(imem_en), 32'd1);
        step(); step(); #2; chk("t5_n3_pc", out_pc, RESET_PC);

        // 6: PC wrap, then pointer wrap under an irregular ready pattern
        step(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        step(); redirect_valid = 1'b0;
        #2; chk("t6_addr_max", imem_addr, 32'hFFFF_FFFF); chk("t6_en", 32'(imem_en), 32'd1);
        step(); #2; chk("t6_addr_wrap", imem_addr, 32'd0);
        step(); #2; chk("t6_pc_max", out_pc, 32'hFFFF_FFFF); chk("t6_instr_max", out_instr, 32'h0000_00FF);
        step(); #2; chk("t6_pc_zero", out_pc, 32'd0); chk("t6_instr_zero", out_instr, 32'h100);
        pat = 32'b1011_0010_1110_0001_1101_0110_0011_1001;
        for (int i = 0; i < 48; i++) begin
            step();
            out_ready = pat[i % 32];
        end
        out_ready = 1'b1;
        repeat (8) step();

        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
